// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding bytes from NUM_REQ requesters to a single UART transmitter.
// Optional ISSUE-state watchdog is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       arb_busy,
    output logic                       timeout_err
);

    localparam int unsigned GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [7:0]           req_byte [NUM_REQ];
    logic                 found;
    logic [GW-1:0]        pick;
    logic [7:0]           tx_data_nxt;
    logic                 tx_valid_nxt;
    logic [NUM_REQ-1:0]   ack_nxt;
    logic [GW-1:0]        grant_id_nxt;
    logic                 timeout_hit;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_err
        $error("uart_tx_arbiter: unsupported NUM_REQ/TIMEOUT_CYC");
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    // Search begins one past the last grant and wraps, so grant_id doubles as the RR pointer.
    always_comb begin : rr_search
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = grant_id;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = 32'(grant_id) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[GW'(idx)]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        tx_data_nxt  = tx_data;
        tx_valid_nxt = tx_valid;
        ack_nxt      = '0;
        grant_id_nxt = grant_id;
        case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    tx_data_nxt   = req_byte[pick];
                    tx_valid_nxt  = 1'b1;
                    ack_nxt[pick] = 1'b1;
                    grant_id_nxt  = pick;
                    state_nxt     = ISSUE;
                end
            end
            ISSUE: begin
                if (tx_busy) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = DRAIN;
                end else if (timeout_hit) begin
                    tx_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            DRAIN: begin
                if (!tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                tx_valid_nxt = 1'b0;
                state_nxt    = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            ack      <= '0;
            grant_id <= GW'(NUM_REQ - 1);
            arb_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            tx_data  <= tx_data_nxt;
            tx_valid <= tx_valid_nxt;
            ack      <= ack_nxt;
            grant_id <= grant_id_nxt;
            arb_busy <= (state_nxt != IDLE);
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] wd_cnt;

    // Counter holds the number of completed ISSUE cycles; it is zero on the cycle after a grant.
    assign timeout_hit = (wd_cnt == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ISSUE && state_nxt == ISSUE) begin
                wd_cnt <= wd_cnt + CW'(1);
            end else begin
                wd_cnt <= '0;
            end
            if (state == ISSUE && !tx_busy && timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYC=16).
module tb_uart_tx_arbiter;

    localparam int unsigned N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        arb_busy;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_data   (req_data),
        .ack        (ack),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .arb_busy   (arb_busy),
        .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full handshake: grant, hold one cycle, busy sampled, busy released.
    task automatic serve(input int unsigned g, input logic [7:0] d);
        tick;
        check("grant_ack",      32'(ack),      32'(1) << g);
        check("grant_valid",    32'(tx_valid), 32'd1);
        check("grant_data",     32'(tx_data),  32'(d));
        check("grant_id",       32'(grant_id), g);
        check("grant_arb_busy", 32'(arb_busy), 32'd1);
        tick;
        check("issue_ack_low",  32'(ack),      32'd0);
        check("issue_valid",    32'(tx_valid), 32'd1);
        check("issue_data",     32'(tx_data),  32'(d));
        tx_busy = 1'b1;
        tick;
        check("drain_valid",    32'(tx_valid), 32'd0);
        check("drain_arb_busy", 32'(arb_busy), 32'd1);
        tx_busy = 1'b0;
        tick;
        check("idle_arb_busy",  32'(arb_busy), 32'd0);
        check("idle_ack",       32'(ack),      32'd0);
    endtask

    initial begin
        logic dropped;
        rst_n    = 1'b0;
        req      = 4'b0001;
        req_data = 32'h0000_0041;
        tx_busy  = 1'b0;

        // Reset values, with a request already pending
        tick;
        tick;
        check("rst_valid",   32'(tx_valid),    32'd0);
        check("rst_data",    32'(tx_data),     32'h00);
        check("rst_ack",     32'(ack),         32'd0);
        check("rst_gid",     32'(grant_id),    32'd3);
        check("rst_busy",    32'(arb_busy),    32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);

        // Single byte, busy rises so tx_valid lasts exactly two cycles
        rst_n = 1'b1;
        serve(0, 8'h41);
        req = '0;

        // Round robin with all requesters held high
        rst_n = 1'b0;
        tick;
        check("rst2_gid", 32'(grant_id), 32'd3);
        rst_n    = 1'b1;
        req      = 4'b1111;
        req_data = 32'h4332_2110;
        serve(0, 8'h10);
        serve(1, 8'h21);
        serve(2, 8'h32);
        serve(3, 8'h43);
        serve(0, 8'h10);

        // Transmitter busy while idle blocks the grant
        req     = 4'b0100;
        tx_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("blocked_ack",   32'(ack),      32'd0);
            check("blocked_valid", 32'(tx_valid), 32'd0);
        end
        tx_busy = 1'b0;
        tick;
        check("unblock_ack",  32'(ack),      32'b0100);
        check("unblock_gid",  32'(grant_id), 32'd2);
        check("unblock_data", 32'(tx_data),  32'h32);
        req = '0;

        // Asynchronous reset three cycles into ISSUE
        tick;
        tick;
        tick;
        check("pre_rst_valid", 32'(tx_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(tx_valid), 32'd0);
        check("async_gid",   32'(grant_id), 32'd3);
        check("async_busy",  32'(arb_busy), 32'd0);
        check("async_ack",   32'(ack),      32'd0);
        check("async_data",  32'(tx_data),  32'h00);
        tick;
        rst_n = 1'b1;
        tick;
        tick;
        check("post_rst_ack",   32'(ack),      32'd0);
        check("post_rst_valid", 32'(tx_valid), 32'd0);
        check("post_rst_busy",  32'(arb_busy), 32'd0);

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: tx_busy never rises, valid drops after 16 ISSUE cycles
        req = 4'b0001;
        tick;
        check("wd_grant_valid", 32'(tx_valid), 32'd1);
        req = '0;
        repeat (15) tick;
        check("wd_valid_15", 32'(tx_valid),    32'd1);
        check("wd_err_15",   32'(timeout_err), 32'd0);
        tick;
        check("wd_valid_16", 32'(tx_valid),    32'd0);
        check("wd_err_16",   32'(timeout_err), 32'd1);
        check("wd_idle",     32'(arb_busy),    32'd0);
        req = 4'b0010;
        serve(1, 8'h21);
        req = '0;
        check("wd_err_sticky", 32'(timeout_err), 32'd1);
`else
        // No watchdog: ISSUE waits indefinitely
        req = 4'b0001;
        tick;
        check("nowd_grant_valid", 32'(tx_valid), 32'd1);
        req     = '0;
        dropped = 1'b0;
        repeat (5000) begin
            tick;
            if (tx_valid !== 1'b1) dropped = 1'b1;
        end
        check("nowd_never_dropped", 32'(dropped),     32'd0);
        check("nowd_valid",         32'(tx_valid),    32'd1);
        check("nowd_err",           32'(timeout_err), 32'd0);
        check("nowd_busy",          32'(arb_busy),    32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of byte requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, ISSUE-state watchdog limit in clk cycles (used only with REQ-030).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NUM_REQ  per-requester level request, one byte pending.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
REQ-007 SHALL have port ack  output  NUM_REQ  one-cycle pulse, byte of requester i accepted.
REQ-008 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-009 SHALL have port tx_valid  output  1  data-valid to the transmitter.
REQ-010 SHALL have port tx_busy  input  1  transmitter busy flag.
REQ-011 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the last granted requester.
REQ-012 SHALL have port arb_busy  output  1  high whenever state is not IDLE.
REQ-013 SHALL have port timeout_err  output  1  sticky watchdog flag.

Function
REQ-014 SHALL implement states IDLE, ISSUE, DRAIN; all outputs registered.
REQ-015 IDLE: when any req bit high and tx_busy low, SHALL grant one requester, latch its req_data into tx_data, pulse ack[g], set tx_valid=1, grant_id=g, go to ISSUE; all on the same clock edge (1-cycle latency req->tx_valid).
REQ-016 IDLE with tx_busy high SHALL not grant; requests wait.
REQ-017 Grant SHALL be round-robin: search starts at (last grant + 1) mod NUM_REQ, wrapping; reset pointer NUM_REQ-1 so requester 0 wins first.
REQ-018 ISSUE: tx_valid and tx_data SHALL be held stable until tx_busy is sampled high, then tx_valid=0 and go to DRAIN.
REQ-019 DRAIN: SHALL wait for tx_busy sampled low, then return to IDLE; no grant in that same cycle.
REQ-020 req/req_data changes in ISSUE or DRAIN SHALL be ignored; requester keeping req high after ack is a new byte.
REQ-021 ack SHALL never have more than one bit high, and SHALL be high exactly one cycle per grant.
REQ-022 A requester with req high SHALL be granted within NUM_REQ grants (no starvation).

Reset
REQ-023 rst_n low SHALL asynchronously force: state IDLE, tx_valid 0, tx_data 0x00, ack 0, grant_id NUM_REQ-1, arb_busy 0, timeout_err 0, watchdog counter 0.
REQ-024 Reset mid-ISSUE or mid-DRAIN SHALL abandon the byte; no ack re-pulse after release.
REQ-025 First grant after rst_n deassertion SHALL occur no earlier than the first clk edge with rst_n high.

Configuration
REQ-030 Macro UART_ARB_TIMEOUT_EN defined: a counter runs in ISSUE; after TIMEOUT_CYC cycles without tx_busy high SHALL drop tx_valid, set timeout_err (sticky until reset), return to IDLE with pointer advanced.
REQ-031 Macro UART_ARB_TIMEOUT_EN undefined: no counter, ISSUE waits indefinitely, timeout_err tied 0.

Verification
REQ-040 Reset, req=4'b0001, req_data[7:0]=0x41, tx_busy rises 2 cycles after tx_valid -> ack=0001 one cycle, tx_data=0x41, tx_valid high exactly 2 cycles.
REQ-041 req=4'b1111 held, each byte served with tx_busy pulse -> grant order 0,1,2,3,0; ack one-hot each grant.
REQ-042 req=4'b0100 while tx_busy high in IDLE for 10 cycles -> no ack, tx_valid 0; grant next cycle after tx_busy low.
REQ-043 rst_n asserted 3 cycles into ISSUE -> tx_valid 0 immediately (async), grant_id=3, arb_busy 0.
REQ-044 UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, tx_busy held 0 -> tx_valid drops after 16 ISSUE cycles, timeout_err=1, stays 1 through next successful byte.
REQ-045 Without UART_ARB_TIMEOUT_EN, same stimulus for 5000 cycles -> tx_valid stays 1, timeout_err 0.
